// File: rtl/prog_loader_if.sv
// Program-image word stream: a source pushes 32-bit words, the loader accepts them.
interface prog_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  // Word source: drives valid and data, observes ready.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  // Loader side: consumes valid and data, drives ready.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Bring-up loader: streams a program image into instruction memory while the
// core is held in reset, then releases the core and runs it until a halt word
// is fetched or the cycle budget runs out.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter logic [31:0] HALT_WORD    = 32'hFC000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  prog_loader_if.slave          inStream,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  input  logic [31:0]           cpu_inst,
  output logic                  cpu_reset,
  output logic                  pc_write,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  error
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned RST_W = 4;
  localparam int unsigned RUN_W = 32;
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(1 << ADDR_WIDTH);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    RELEASE,
    RUN,
    HALTED,
    ERROR
  } stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] numWords, numWordsNext;
  logic [CNT_W-1:0] wordCnt, wordCntNext;
  logic [RST_W-1:0] rstCnt, rstCntNext;
  logic [RUN_W-1:0] runCnt, runCntNext;

  logic                  weNext;
  logic [ADDR_WIDTH-1:0] addrNext;
  logic [31:0]           wdataNext;
  logic                  timeoutNext;
  logic                  inReadyNext;
  logic                  cpuResetNext;
  logic                  pcWriteNext;
  logic                  busyNext;
  logic                  doneNext;
  logic                  errorNext;

  logic             accept;
  logic [CNT_W-1:0] hdrWords;
  logic             hdrBad;

  // State and registered outputs; status flags are flops decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      numWords          <= '0;
      wordCnt           <= '0;
      rstCnt            <= '0;
      runCnt            <= '0;
      imem_we           <= 1'b0;
      imem_addr         <= '0;
      imem_wdata        <= '0;
      inStream.in_ready <= 1'b0;
      cpu_reset         <= 1'b1;
      pc_write          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout           <= 1'b0;
      error             <= 1'b0;
    end else begin
      state             <= stateNext;
      numWords          <= numWordsNext;
      wordCnt           <= wordCntNext;
      rstCnt            <= rstCntNext;
      runCnt            <= runCntNext;
      imem_we           <= weNext;
      imem_addr         <= addrNext;
      imem_wdata        <= wdataNext;
      inStream.in_ready <= inReadyNext;
      cpu_reset         <= cpuResetNext;
      pc_write          <= pcWriteNext;
      busy              <= busyNext;
      done              <= doneNext;
      timeout           <= timeoutNext;
      error             <= errorNext;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    stateNext    = state;
    numWordsNext = numWords;
    wordCntNext  = wordCnt;
    rstCntNext   = rstCnt;
    runCntNext   = runCnt;
    weNext       = 1'b0;
    addrNext     = imem_addr;
    wdataNext    = imem_wdata;
    timeoutNext  = timeout;

    accept   = inStream.in_valid & inStream.in_ready;
    hdrWords = inStream.in_data[ADDR_WIDTH:0];
    hdrBad   = (hdrWords == '0) || (hdrWords > DEPTH) ||
               (inStream.in_data[31:ADDR_WIDTH+1] != '0);

    case (state)
      IDLE, HALTED, ERROR: begin
        if (start) begin
          stateNext   = HEADER;
          timeoutNext = 1'b0;
        end
      end
      HEADER: begin
        if (accept) begin
          if (hdrBad) begin
            stateNext = ERROR;
          end else begin
            stateNext    = LOAD;
            numWordsNext = hdrWords;
            wordCntNext  = '0;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          weNext      = 1'b1;
          addrNext    = wordCnt[ADDR_WIDTH-1:0];
          wdataNext   = inStream.in_data;
          wordCntNext = wordCnt + CNT_W'(1);
          if (wordCnt == numWords - CNT_W'(1)) begin
            stateNext  = RELEASE;
            rstCntNext = '0;
          end
        end
      end
      RELEASE: begin
        if (rstCnt == RST_LAST) begin
          stateNext  = RUN;
          runCntNext = '0;
        end else begin
          rstCntNext = rstCnt + RST_W'(1);
        end
      end
      RUN: begin
        runCntNext = runCnt + RUN_W'(1);
        if (cpu_inst == HALT_WORD) begin
          stateNext   = HALTED;
          timeoutNext = 1'b0;
        end else if (runCnt == RUN_LAST) begin
          stateNext   = HALTED;
          timeoutNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    inReadyNext  = (stateNext == HEADER) || (stateNext == LOAD);
    cpuResetNext = !((stateNext == RUN) || (stateNext == HALTED));
    pcWriteNext  = (stateNext == RUN);
    busyNext     = (stateNext == HEADER) || (stateNext == LOAD) ||
                   (stateNext == RELEASE) || (stateNext == RUN);
    doneNext     = (stateNext == HALTED);
    errorNext    = (stateNext == ERROR);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load/run/halt, timeout, bad headers,
// gapped stream and reset in the middle of a load.
module tb_prog_loader;
  localparam int unsigned AW = 8;
  localparam logic [31:0] HALT = 32'hFC000000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [31:0]   cpu_inst;
  logic          cpu_reset;
  logic          pc_write;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          error;

  int checks = 0;
  int errors = 0;

  prog_loader_if stream ();

  prog_loader #(
    .ADDR_WIDTH  (AW),
    .RESET_CYCLES(2),
    .MAX_CYCLES  (10),
    .HALT_WORD   (HALT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .inStream  (stream),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_inst  (cpu_inst),
    .cpu_reset (cpu_reset),
    .pc_write  (pc_write),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pcCnt;
    logic [31:0] prog [3];
    prog[0] = 32'h20080005;
    prog[1] = 32'h20090007;
    prog[2] = HALT;

    reset = 1'b1;
    start = 1'b0;
    stream.in_valid = 1'b0;
    stream.in_data  = '0;
    cpu_inst = '0;
    step();
    step();

    // Reset state
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_in_ready", 32'(stream.in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_flags", {28'd0, busy, done, timeout, error}, 32'd0);

    reset = 1'b0;
    step();
    chk("idle_in_ready", 32'(stream.in_ready), 32'd0);

    // Load 3 words back-to-back, then release and run
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hdr_in_ready", 32'(stream.in_ready), 32'd1);
    chk("hdr_busy", 32'(busy), 32'd1);
    stream.in_valid = 1'b1;
    stream.in_data  = 32'd3;
    step();
    chk("load_in_ready", 32'(stream.in_ready), 32'd1);
    chk("load_no_we_after_hdr", 32'(imem_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      stream.in_data = prog[i];
      step();
      chk("b2b_we", 32'(imem_we), 32'd1);
      chk("b2b_addr", 32'(imem_addr), 32'(i));
      chk("b2b_wdata", imem_wdata, prog[i]);
      chk("b2b_cpu_reset", 32'(cpu_reset), 32'd1);
    end
    stream.in_valid = 1'b0;
    chk("rel_in_ready", 32'(stream.in_ready), 32'd0);
    step();
    chk("rel_we_low", 32'(imem_we), 32'd0);
    chk("rel_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rel_pc_write", 32'(pc_write), 32'd0);
    step();
    chk("run_pc_write", 32'(pc_write), 32'd1);
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);

    // Halt word fetched in the 4th RUN cycle
    step();
    step();
    step();
    chk("run4_pc_write", 32'(pc_write), 32'd1);
    cpu_inst = HALT;
    step();
    cpu_inst = '0;
    chk("halt_pc_write", 32'(pc_write), 32'd0);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_timeout", 32'(timeout), 32'd0);
    chk("halt_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("halt_busy", 32'(busy), 32'd0);

    // Budget of 10 run cycles with no halt word
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    stream.in_valid = 1'b1;
    stream.in_data  = 32'd1;
    step();
    stream.in_data = 32'h12345678;
    step();
    stream.in_valid = 1'b0;
    chk("to_wdata", imem_wdata, 32'h12345678);
    step();
    step();
    chk("to_run_start", 32'(pc_write), 32'd1);
    pcCnt = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (pc_write) pcCnt++;
      if (done) break;
    end
    chk("to_pc_cycles", 32'(pcCnt), 32'd10);
    chk("to_done", 32'(done), 32'd1);
    chk("to_timeout", 32'(timeout), 32'd1);

    // Bad headers: zero words, then 257 words
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hdr0_timeout_clr", 32'(timeout), 32'd0);
    stream.in_valid = 1'b1;
    stream.in_data  = 32'd0;
    step();
    stream.in_valid = 1'b0;
    chk("hdr0_error", 32'(error), 32'd1);
    chk("hdr0_in_ready", 32'(stream.in_ready), 32'd0);
    chk("hdr0_cpu_reset", 32'(cpu_reset), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_clear", 32'(error), 32'd0);
    stream.in_valid = 1'b1;
    stream.in_data  = 32'd257;
    step();
    stream.in_valid = 1'b0;
    chk("hdr257_error", 32'(error), 32'd1);
    chk("hdr257_in_ready", 32'(stream.in_ready), 32'd0);

    // Recovery: header 1, one zero word, run to halt
    start = 1'b1;
    step();
    start = 1'b0;
    stream.in_valid = 1'b1;
    stream.in_data  = 32'd1;
    step();
    chk("rec_load", 32'(stream.in_ready), 32'd1);
    stream.in_data = 32'h0;
    step();
    stream.in_valid = 1'b0;
    chk("rec_we", 32'(imem_we), 32'd1);
    chk("rec_addr", 32'(imem_addr), 32'd0);
    step();
    step();
    chk("rec_pc_write", 32'(pc_write), 32'd1);
    cpu_inst = HALT;
    step();
    cpu_inst = '0;
    chk("rec_done", 32'(done), 32'd1);

    // Gapped stream, start ignored mid-load, held valid in RELEASE not consumed
    start = 1'b1;
    step();
    start = 1'b0;
    stream.in_valid = 1'b1;
    stream.in_data  = 32'd4;
    step();
    for (int i = 0; i < 4; i++) begin
      stream.in_valid = 1'b1;
      stream.in_data  = 32'hA0 + 32'(i);
      step();
      chk("gap_we", 32'(imem_we), 32'd1);
      chk("gap_addr", 32'(imem_addr), 32'(i));
      chk("gap_wdata", imem_wdata, 32'hA0 + 32'(i));
      stream.in_valid = (i == 3);
      start = (i == 1);
      step();
      start = 1'b0;
      chk("gap_we_low", 32'(imem_we), 32'd0);
    end
    chk("gap_rel_busy", 32'(busy), 32'd1);
    stream.in_valid = 1'b0;
    cpu_inst = HALT;
    step();
    chk("gap_run", 32'(pc_write), 32'd1);
    step();
    cpu_inst = '0;
    chk("gap_done", 32'(done), 32'd1);

    // Reset during a 5-word load after 2 words
    start = 1'b1;
    step();
    start = 1'b0;
    stream.in_valid = 1'b1;
    stream.in_data  = 32'd5;
    step();
    for (int i = 0; i < 2; i++) begin
      stream.in_data = 32'h55 + 32'(i);
      step();
      chk("mid_we", 32'(imem_we), 32'd1);
      chk("mid_addr", 32'(imem_addr), 32'(i));
    end
    reset = 1'b1;
    step();
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_in_ready", 32'(stream.in_ready), 32'd0);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    stream.in_valid = 1'b0;
    reset = 1'b0;
    step();
    chk("mid_rst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Bring-up stage directly upstream of the single-cycle CPU core.
- Accepts a program image over a valid/ready word stream and writes it into instruction memory while the core is held in reset.
- Then releases the core and drives its PCWrite enable until a halt instruction is fetched or a cycle budget expires.
- Reports done, timeout and error status to the test harness.

Parameters:
- ADDR_WIDTH, 8: instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- RESET_CYCLES, 2: cycles the core reset stays high in RELEASE before PCWrite is enabled (legal range 1..15).
- MAX_CYCLES, 1000: core run-cycle budget before forced halt; 32-bit counter.
- HALT_WORD, 32'hFC000000: instruction encoding that stops execution.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, HALTED or ERROR.
- in_valid  in  1  stream word valid.
- in_data  in  32  stream word; first word is the header, the rest are program words.
- in_ready  out  1  loader can accept a word.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  instruction-memory word address.
- imem_wdata  out  32  instruction-memory write data.
- cpu_inst  in  32  instruction currently fetched by the core.
- cpu_reset  out  1  reset to the core, active high.
- pc_write  out  1  PCWrite enable to the core.
- busy  out  1  high in HEADER, LOAD, RELEASE and RUN.
- done  out  1  high in HALTED.
- timeout  out  1  set when HALTED was reached on the cycle budget; cleared on start.
- error  out  1  high in ERROR.

Behaviour:
- Reset (async):
  - state=IDLE, cpu_reset=1, pc_write=0, in_ready=0.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - done=0, timeout=0, error=0; all counters cleared.
- All outputs are registered. in_ready and the status flags are decoded from the registered state.
- IDLE:
  - cpu_reset=1.
  - start -> HEADER.
- HEADER:
  - in_ready=1.
  - On in_valid&in_ready: N = in_data[ADDR_WIDTH:0].
  - If N==0, N>2^ADDR_WIDTH, or in_data[31:ADDR_WIDTH+1]!=0 -> ERROR.
  - Otherwise -> LOAD with word counter=0.
- LOAD:
  - in_ready=1.
  - Each handshake: next cycle imem_we=1, imem_addr=counter, imem_wdata=in_data; counter increments. Write latency is exactly 1 cycle.
  - When in_valid is low, imem_we=0 the next cycle.
  - The handshake with counter==N-1 -> RELEASE. in_ready drops the cycle after it.
  - Back-to-back beats are supported at 1 word/cycle.
  - Address wraps never occur because N is bounded.
- RELEASE:
  - in_ready=0, cpu_reset=1 for RESET_CYCLES cycles.
  - Then cpu_reset=0 and pc_write=1 in the same cycle; state -> RUN with cycle counter=0.
- RUN:
  - pc_write=1; the cycle counter increments every cycle.
  - If cpu_inst==HALT_WORD: next cycle pc_write=0, state=HALTED, timeout=0.
  - Else if counter==MAX_CYCLES-1: next cycle pc_write=0, state=HALTED, timeout=1.
  - If both are true in the same cycle, the halt-word condition wins (timeout=0).
- HALTED:
  - done=1, pc_write=0, cpu_reset=0 (core state is kept for inspection).
  - start -> HEADER, with cpu_reset=1 and done=0 the next cycle and timeout cleared.
- ERROR:
  - error=1, cpu_reset=1.
  - start -> HEADER and clears error.
- start in HEADER, LOAD, RELEASE or RUN is ignored.
- in_valid while in_ready=0 is not consumed; the source must hold the word.
- Reset asserted mid-load or mid-run returns immediately to IDLE with the reset values above. The partially written memory is not scrubbed.

Test Plan:
- Reset, start, header 3, words 0x20080005, 0x20090007, 0xFC000000 on consecutive cycles -> imem_we high 3 consecutive cycles at addr 0,1,2 with matching data; cpu_reset high 2 more cycles, then pc_write=1.
- Same load, then drive cpu_inst=0xFC000000 in the 4th RUN cycle -> pc_write=0 and done=1 the next cycle, timeout=0.
- MAX_CYCLES=10, cpu_inst never equals HALT_WORD -> pc_write high exactly 10 cycles; done=1 and timeout=1.
- Header 0, then header 257 (ADDR_WIDTH=8) -> error=1 and in_ready=0 each time; a following start plus header 1 with word 0x00000000 recovers normally.
- Gapped stream: valid asserted every other cycle for 4 words -> 4 writes at addr 0..3, each 1 cycle after its handshake, with no extra strobes.
- Assert reset during LOAD after 2 of 5 words -> next edge: state IDLE, cpu_reset=1, in_ready=0, imem_we=0, busy=0.
